// File: rtl/pe_window_seq.sv
// pe_window_seq: layer sequencer walking window/channel/kernel-row/column beats into FM/WT reads and PE states
module pe_window_seq #(
  parameter int FM_BUF_DEPTH = 18432,
  parameter int WT_BUF_DEPTH = 512,
  parameter int FM_AW = 15,
  parameter int WT_AW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_kernel_mode,
  input  logic [11:0]      cfg_n_window,
  input  logic [7:0]       cfg_n_ch,
  input  logic [FM_AW-1:0] cfg_fm_base,
  input  logic [WT_AW-1:0] cfg_wt_base,
  input  logic             pe_ready,
  output logic             fm_rd_en,
  output logic [FM_AW-1:0] fm_rd_addr,
  output logic             wt_rd_en,
  output logic [WT_AW-1:0] wt_rd_addr,
  output logic             pe_valid,
  output logic [2:0]       pe_state,
  output logic             win_first,
  output logic             win_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [2:0] {IDLE, ONE, TWO, THREE, FOUR, FIVE, SIX} pe_state_t;
  state_t st;
  logic k5;
  logic [11:0] n_win, w;
  logic [7:0] n_ch, c;
  logic [2:0] r, s;
  logic [WT_AW-1:0] wt_base;
  logic row_end, k_last, ch_last, win_end, last_beat;
  assign row_end = s == 3'd5;
  assign k_last = r == (k5 ? 3'd4 : 3'd2);
  assign ch_last = c == n_ch - 8'd1;
  assign win_end = row_end && k_last && ch_last;
  assign last_beat = win_end && w == n_win - 12'd1;
  assign fm_rd_en = st == S_RUN && pe_ready;
  assign wt_rd_en = fm_rd_en;
  assign busy = st != S_IDLE;
  assign done = st == S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      k5 <= 1'b0;
      n_win <= '0;
      n_ch <= '0;
      wt_base <= '0;
      w <= '0;
      c <= '0;
      r <= '0;
      s <= '0;
      fm_rd_addr <= '0;
      wt_rd_addr <= '0;
      pe_valid <= 1'b0;
      pe_state <= 3'(IDLE);
      win_first <= 1'b0;
      win_last <= 1'b0;
    end else begin
      pe_valid <= fm_rd_en;
      pe_state <= fm_rd_en ? s + 3'(ONE) : 3'(IDLE);
      win_first <= fm_rd_en && s == 3'd0 && r == 3'd0 && c == 8'd0;
      win_last <= fm_rd_en && win_end;
      case (st)
        S_IDLE: if (start) begin
          k5 <= cfg_kernel_mode;
          n_win <= cfg_n_window;
          n_ch <= cfg_n_ch;
          wt_base <= cfg_wt_base;
          w <= '0;
          c <= '0;
          r <= '0;
          s <= '0;
          fm_rd_addr <= cfg_fm_base;
          wt_rd_addr <= cfg_wt_base;
          st <= (cfg_n_window == 12'd0 || cfg_n_ch == 8'd0) ? S_DRAIN : S_RUN;
        end
        S_RUN: if (pe_ready) begin
          fm_rd_addr <= fm_rd_addr == FM_AW'(FM_BUF_DEPTH - 1) ? '0 : fm_rd_addr + 1'b1;
          s <= row_end ? 3'd0 : s + 3'd1;
          // c*K+r steps by one per kernel row, so the WT address is a running wrap-increment
          if (row_end) begin
            r <= k_last ? 3'd0 : r + 3'd1;
            wt_rd_addr <= win_end ? wt_base
                        : wt_rd_addr == WT_AW'(WT_BUF_DEPTH - 1) ? '0 : wt_rd_addr + 1'b1;
          end
          if (row_end && k_last) c <= ch_last ? 8'd0 : c + 8'd1;
          if (win_end) w <= w + 12'd1;
          if (last_beat) st <= S_DRAIN;
        end
        S_DRAIN: st <= S_DONE;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
